// File: rtl/write_reg_track.sv
// Execute-stage destination resolver with DEPTH-stage tracking and fwd selects.
// Optional link path: define WRITEREG_LINK_EN to route mode 10 to LINK_REG.
module write_reg_track #(
  parameter int R_W      = 5,
  parameter int DEPTH    = 2,
  parameter int LINK_REG = 31,
  parameter int S_W      = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           reg_dst_e,
  input  logic                 reg_write_e,
  input  logic [R_W-1:0]       rt_e,
  input  logic [R_W-1:0]       rd_e,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [R_W-1:0]       src_a,
  input  logic [R_W-1:0]       src_b,
  output logic [R_W-1:0]       write_reg_e,
  output logic [DEPTH*R_W-1:0] write_reg_pipe,
  output logic [DEPTH-1:0]     write_valid_pipe,
  output logic [S_W-1:0]       fwd_a_sel,
  output logic [S_W-1:0]       fwd_b_sel
);

`ifdef WRITEREG_LINK_EN
  localparam bit LinkEn = 1'b1;
`else
  localparam bit LinkEn = 1'b0;
`endif

  logic [R_W-1:0] dest_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [R_W-1:0] dst_mux;
  logic           load_valid;

  always_comb begin
    dst_mux = rd_e;
    unique case (reg_dst_e)
      2'b00:   dst_mux = rt_e;
      2'b10:   dst_mux = LinkEn ? R_W'(LINK_REG) : rd_e;
      default: dst_mux = rd_e;
    endcase
  end

  assign write_reg_e = reset ? dst_mux : '0;
  assign load_valid  = reg_write_e && (write_reg_e != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) dest_q[k] <= '0;
      valid_q <= '0;
    end else begin
      if (!stall) begin
        for (int k = DEPTH - 1; k >= 1; k--) begin
          dest_q[k]  <= dest_q[k-1];
          valid_q[k] <= valid_q[k-1];
        end
      end
      // Flush wins stage 1 even under stall so the bubble is never lost.
      if (flush) begin
        dest_q[0]  <= '0;
        valid_q[0] <= 1'b0;
      end else if (!stall) begin
        dest_q[0]  <= write_reg_e;
        valid_q[0] <= load_valid;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++)
      write_reg_pipe[k*R_W +: R_W] = dest_q[k];
  end

  assign write_valid_pipe = valid_q;

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_q[k-1] && dest_q[k-1] == src_a && src_a != '0)
        fwd_a_sel = S_W'(k);
      if (valid_q[k-1] && dest_q[k-1] == src_b && src_b != '0)
        fwd_b_sel = S_W'(k);
    end
  end

endmodule

// File: tb/tb_write_reg_track.sv
// Directed bench for write_reg_track at default parameters (DEPTH=2).
module tb_write_reg_track;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] reg_dst_e;
  logic       reg_write_e;
  logic [4:0] rt_e, rd_e, src_a, src_b;
  logic       stall, flush;
  logic [4:0] write_reg_e;
  logic [9:0] write_reg_pipe;
  logic [1:0] write_valid_pipe;
  logic [2:0] fwd_a_sel, fwd_b_sel;

  int total = 0;
  int bad = 0;

  write_reg_track dut (
    .clock(clock), .reset(reset),
    .reg_dst_e(reg_dst_e), .reg_write_e(reg_write_e),
    .rt_e(rt_e), .rd_e(rd_e),
    .stall(stall), .flush(flush),
    .src_a(src_a), .src_b(src_b),
    .write_reg_e(write_reg_e),
    .write_reg_pipe(write_reg_pipe),
    .write_valid_pipe(write_valid_pipe),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [4:0] d);
    reg_dst_e = 2'b01;
    reg_write_e = w;
    rd_e = d;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    stall = 1'b0; flush = 1'b0;
    reg_dst_e = 2'b01; rd_e = 5'd9; rt_e = 5'd0; reg_write_e = 1'b1;
    src_a = 5'd9; src_b = 5'd9;
    #1;
    total++;
    if (write_reg_e !== 5'd0) begin
      bad++; $display("FAIL rst_wre got=%0d exp=0", write_reg_e);
    end
    tick();
    total++;
    if (write_reg_pipe !== 10'd0 || write_valid_pipe !== 2'b00) begin
      bad++;
      $display("FAIL rst_pipe got=%h/%b exp=0/00", write_reg_pipe, write_valid_pipe);
    end
    total++;
    if (fwd_a_sel !== 3'd0 || fwd_b_sel !== 3'd0) begin
      bad++; $display("FAIL rst_fwd got=%0d/%0d exp=0/0", fwd_a_sel, fwd_b_sel);
    end
    @(negedge clock);
    reset = 1'b1;
    tick();
    total++;
    if (write_reg_pipe[4:0] !== 5'd9 || write_valid_pipe !== 2'b01) begin
      bad++;
      $display("FAIL rst_release got=%0d/%b exp=9/01", write_reg_pipe[4:0], write_valid_pipe);
    end
  endtask

  task automatic test_modes();
    logic [4:0] exp_link;
`ifdef WRITEREG_LINK_EN
    exp_link = 5'd31;
`else
    exp_link = 5'd7;
`endif
    rt_e = 5'd4; rd_e = 5'd7;
    reg_dst_e = 2'b00; #1;
    total++;
    if (write_reg_e !== 5'd4) begin
      bad++; $display("FAIL mode00 got=%0d exp=4", write_reg_e);
    end
    reg_dst_e = 2'b01; #1;
    total++;
    if (write_reg_e !== 5'd7) begin
      bad++; $display("FAIL mode01 got=%0d exp=7", write_reg_e);
    end
    reg_dst_e = 2'b10; #1;
    total++;
    if (write_reg_e !== exp_link) begin
      bad++; $display("FAIL mode10 got=%0d exp=%0d", write_reg_e, exp_link);
    end
    reg_dst_e = 2'b11; #1;
    total++;
    if (write_reg_e !== 5'd7) begin
      bad++; $display("FAIL mode11 got=%0d exp=7", write_reg_e);
    end
  endtask

  task automatic test_forward();
    issue(1'b1, 5'd5);
    issue(1'b1, 5'd6);
    src_a = 5'd5; src_b = 5'd6; #1;
    total++;
    if (fwd_a_sel !== 3'd2 || fwd_b_sel !== 3'd1) begin
      bad++; $display("FAIL fwd_order got=%0d/%0d exp=2/1", fwd_a_sel, fwd_b_sel);
    end
    issue(1'b1, 5'd5);
    total++;
    if (fwd_a_sel !== 3'd1 || fwd_b_sel !== 3'd2) begin
      bad++; $display("FAIL fwd_youngest got=%0d/%0d exp=1/2", fwd_a_sel, fwd_b_sel);
    end
  endtask

  task automatic test_zero_dest();
    issue(1'b1, 5'd0);
    src_a = 5'd0; #1;
    total++;
    if (write_valid_pipe !== 2'b10 || fwd_a_sel !== 3'd0) begin
      bad++;
      $display("FAIL zero_dest got=%b/%0d exp=10/0", write_valid_pipe, fwd_a_sel);
    end
    issue(1'b0, 5'd8);
    src_a = 5'd8; #1;
    total++;
    if (write_reg_pipe[4:0] !== 5'd8 || write_valid_pipe !== 2'b00 || fwd_a_sel !== 3'd0) begin
      bad++;
      $display("FAIL no_write got=%0d/%b/%0d exp=8/00/0",
               write_reg_pipe[4:0], write_valid_pipe, fwd_a_sel);
    end
  endtask

  task automatic test_stall_flush();
    issue(1'b1, 5'd12);
    issue(1'b1, 5'd3);
    total++;
    if (write_reg_pipe !== {5'd12, 5'd3} || write_valid_pipe !== 2'b11) begin
      bad++; $display("FAIL sf_fill got=%h/%b exp=%h/11", write_reg_pipe,
                      write_valid_pipe, {5'd12, 5'd3});
    end
    stall = 1'b1; flush = 1'b1;
    issue(1'b1, 5'd20);
    total++;
    if (write_reg_pipe !== {5'd12, 5'd0} || write_valid_pipe !== 2'b10) begin
      bad++; $display("FAIL stall_flush got=%h/%b exp=%h/10", write_reg_pipe,
                      write_valid_pipe, {5'd12, 5'd0});
    end
    stall = 1'b0; flush = 1'b0;
    issue(1'b1, 5'd17);
    stall = 1'b1;
    issue(1'b1, 5'd25);
    issue(1'b1, 5'd25);
    issue(1'b1, 5'd25);
    total++;
    if (write_reg_pipe !== {5'd0, 5'd17} || write_valid_pipe !== 2'b01) begin
      bad++; $display("FAIL stall_hold got=%h/%b exp=%h/01", write_reg_pipe,
                      write_valid_pipe, {5'd0, 5'd17});
    end
    stall = 1'b0; flush = 1'b1;
    issue(1'b1, 5'd25);
    src_a = 5'd17; #1;
    total++;
    if (write_reg_pipe !== {5'd17, 5'd0} || write_valid_pipe !== 2'b10 || fwd_a_sel !== 3'd2) begin
      bad++; $display("FAIL flush_only got=%h/%b/%0d exp=%h/10/2", write_reg_pipe,
                      write_valid_pipe, fwd_a_sel, {5'd17, 5'd0});
    end
    flush = 1'b0;
  endtask

  task automatic test_async_reset();
    issue(1'b1, 5'd11);
    issue(1'b1, 5'd13);
    src_a = 5'd11; src_b = 5'd13; #1;
    total++;
    if (fwd_a_sel !== 3'd2 || fwd_b_sel !== 3'd1) begin
      bad++; $display("FAIL pre_areset got=%0d/%0d exp=2/1", fwd_a_sel, fwd_b_sel);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if (write_reg_pipe !== 10'd0 || write_valid_pipe !== 2'b00 ||
        fwd_a_sel !== 3'd0 || fwd_b_sel !== 3'd0 || write_reg_e !== 5'd0) begin
      bad++; $display("FAIL areset got=%h/%b/%0d/%0d/%0d exp=0", write_reg_pipe,
                      write_valid_pipe, fwd_a_sel, fwd_b_sel, write_reg_e);
    end
    tick();
    @(negedge clock);
    reset = 1'b1;
    issue(1'b0, 5'd11);
    total++;
    if (write_reg_pipe !== {5'd0, 5'd11} || write_valid_pipe !== 2'b00 ||
        fwd_a_sel !== 3'd0 || fwd_b_sel !== 3'd0) begin
      bad++; $display("FAIL post_areset got=%h/%b/%0d/%0d exp=%h/00/0/0", write_reg_pipe,
                      write_valid_pipe, fwd_a_sel, fwd_b_sel, {5'd0, 5'd11});
    end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_forward();
    test_zero_dest();
    test_stall_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
